// File: rtl/control_unit_hs.sv
// Fetch/decode/execute control FSM for one accumulator core. Memory accesses use
// req/ack handshakes; an optional ack timeout and illegal opcodes end in a sticky FAULT.
module control_unit_hs #(
    parameter int IR_WIDTH    = 8,
    parameter int ACK_TIMEOUT = 0,
    parameter int TO_WIDTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [IR_WIDTH-1:0] ins,
    input  logic                Zout,
    input  logic                imAck,
    input  logic                dmAck,
    output logic                imReq,
    output logic                dmReq,
    output logic                DataMemWrEn,
    output logic [2:0]          aluOp,
    output logic [3:0]          incReg,
    output logic [9:0]          wrEnReg,
    output logic [3:0]          busSel,
    output logic                ZWrEn,
    output logic                ready,
    output logic                done,
    output logic                err
);
    localparam logic [7:0] OP_NOP   = 8'd0;
    localparam logic [7:0] OP_END   = 8'd1;
    localparam logic [7:0] OP_CLAC  = 8'd2;
    localparam logic [7:0] OP_LDIAC = 8'd3;
    localparam logic [7:0] OP_LDAC  = 8'd4;
    localparam logic [7:0] OP_STR   = 8'd5;
    localparam logic [7:0] OP_STIR  = 8'd6;
    localparam logic [7:0] OP_JUMP  = 8'd7;
    localparam logic [7:0] OP_JMPNZ = 8'd8;
    localparam logic [7:0] OP_JMPZ  = 8'd9;
    localparam logic [7:0] OP_MUL   = 8'd10;
    localparam logic [7:0] OP_ADD   = 8'd11;
    localparam logic [7:0] OP_SUB   = 8'd12;
    localparam logic [7:0] OP_INCAC = 8'd13;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_CLR  = 3'd1;
    localparam logic [2:0] ALU_ADD  = 3'd2;
    localparam logic [2:0] ALU_SUB  = 3'd3;
    localparam logic [2:0] ALU_MUL  = 3'd4;
    localparam logic [2:0] ALU_INC  = 3'd5;

    localparam logic [3:0] BUS_DM = 4'd0;
    localparam logic [3:0] BUS_IM = 4'd1;
    localparam logic [3:0] BUS_PC = 4'd2;
    localparam logic [3:0] BUS_AC = 4'd3;
    localparam logic [3:0] BUS_RL = 4'd4;
    localparam logic [3:0] BUS_RP = 4'd5;
    localparam logic [3:0] BUS_RQ = 4'd6;

    localparam int WR_AC = 0;
    localparam int WR_R1 = 1;
    localparam int WR_RQ = 2;
    localparam int WR_RP = 3;
    localparam int WR_RC = 4;
    localparam int WR_RL = 5;
    localparam int WR_IR = 6;
    localparam int WR_PC = 7;
    localparam int WR_R  = 8;
    localparam int WR_AR = 9;

    localparam int INC_PC = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_ALU, S_MV, S_LD, S_ST,
        S_OPR1, S_OPR2, S_SKIP, S_DONE, S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [TO_WIDTH-1:0] wait_q, wait_d;
    logic                waiting;
    logic                timeout;
    logic [7:0]          opcode;
    logic                is_mv;

    assign opcode = ins[7:0];
    assign is_mv  = (opcode[3:0] == 4'hF) && (opcode[7:4] >= 4'd1) && (opcode[7:4] <= 4'd9);

    generate
        if (IR_WIDTH > 8) begin : g_ins_hi
            logic ins_hi_unused;
            assign ins_hi_unused = ^ins[IR_WIDTH-1:8];
        end
    endgenerate

    // A wait state with no ack this cycle is what the timeout counter measures.
    always_comb begin
        waiting = 1'b0;
        case (state_q)
            S_FETCH2, S_OPR2: waiting = !imAck;
            S_LD, S_ST:       waiting = !dmAck;
            default:          waiting = 1'b0;
        endcase
    end

    assign timeout = (ACK_TIMEOUT != 0) && waiting && (wait_q == TO_WIDTH'(ACK_TIMEOUT));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        imReq       = 1'b0;
        dmReq       = 1'b0;
        DataMemWrEn = 1'b0;
        aluOp       = ALU_PASS;
        incReg      = '0;
        wrEnReg     = '0;
        busSel      = BUS_DM;
        ZWrEn       = 1'b0;
        ready       = 1'b0;
        done        = 1'b0;
        err         = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_d = S_FETCH1;
            end
            S_FETCH1, S_OPR1: begin
                busSel          = BUS_PC;
                wrEnReg[WR_AR]  = 1'b1;
                state_d         = (state_q == S_FETCH1) ? S_FETCH2 : S_OPR2;
            end
            S_FETCH2: begin
                imReq = 1'b1;
                if (imAck) begin
                    busSel          = BUS_IM;
                    wrEnReg[WR_IR]  = 1'b1;
                    incReg[INC_PC]  = 1'b1;
                    state_d         = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                // The opcode is kept so later states need not rely on IR staying put.
                op_d = opcode;
                case (opcode)
                    OP_NOP:                                   state_d = S_FETCH1;
                    OP_END:                                   state_d = S_DONE;
                    OP_CLAC, OP_MUL, OP_ADD, OP_SUB, OP_INCAC: state_d = S_ALU;
                    OP_LDAC:                                  state_d = S_LD;
                    OP_STR:                                   state_d = S_ST;
                    OP_LDIAC, OP_STIR, OP_JUMP:               state_d = S_OPR1;
                    OP_JMPZ:                                  state_d = Zout ? S_OPR1 : S_SKIP;
                    OP_JMPNZ:                                 state_d = Zout ? S_SKIP : S_OPR1;
                    default:                                  state_d = is_mv ? S_MV : S_FAULT;
                endcase
            end
            S_ALU: begin
                case (op_q)
                    OP_CLAC: aluOp = ALU_CLR;
                    OP_MUL:  aluOp = ALU_MUL;
                    OP_ADD:  aluOp = ALU_ADD;
                    OP_SUB:  aluOp = ALU_SUB;
                    default: aluOp = ALU_INC;
                endcase
                wrEnReg[WR_AC] = 1'b1;
                ZWrEn          = 1'b1;
                state_d        = S_FETCH1;
            end
            S_MV: begin
                case (op_q[7:4])
                    4'd1: begin busSel = BUS_AC; wrEnReg[WR_RL] = 1'b1; end
                    4'd2: begin busSel = BUS_AC; wrEnReg[WR_RP] = 1'b1; end
                    4'd3: begin busSel = BUS_AC; wrEnReg[WR_RQ] = 1'b1; end
                    4'd4: begin busSel = BUS_AC; wrEnReg[WR_RC] = 1'b1; end
                    4'd5: begin busSel = BUS_AC; wrEnReg[WR_R]  = 1'b1; end
                    4'd6: begin busSel = BUS_AC; wrEnReg[WR_R1] = 1'b1; end
                    4'd7: begin busSel = BUS_RP; wrEnReg[WR_AC] = 1'b1; end
                    4'd8: begin busSel = BUS_RQ; wrEnReg[WR_AC] = 1'b1; end
                    4'd9: begin busSel = BUS_RL; wrEnReg[WR_AC] = 1'b1; end
                    default: ;
                endcase
                state_d = S_FETCH1;
            end
            S_OPR2: begin
                imReq = 1'b1;
                if (imAck) begin
                    busSel = BUS_IM;
                    if (op_q == OP_LDIAC || op_q == OP_STIR) begin
                        wrEnReg[WR_AR] = 1'b1;
                        incReg[INC_PC] = 1'b1;
                        state_d        = (op_q == OP_LDIAC) ? S_LD : S_ST;
                    end else begin
                        wrEnReg[WR_PC] = 1'b1;
                        state_d        = S_FETCH1;
                    end
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_LD: begin
                dmReq = 1'b1;
                if (dmAck) begin
                    busSel         = BUS_DM;
                    aluOp          = ALU_PASS;
                    wrEnReg[WR_AC] = 1'b1;
                    ZWrEn          = 1'b1;
                    state_d        = S_FETCH1;
                end else if (timeout) begin
                    state_d = S_FAULT;
                end
            end
            S_ST: begin
                dmReq       = 1'b1;
                DataMemWrEn = 1'b1;
                busSel      = BUS_AC;
                if (dmAck)        state_d = S_FETCH1;
                else if (timeout) state_d = S_FAULT;
            end
            S_SKIP: begin
                incReg[INC_PC] = 1'b1;
                state_d        = S_FETCH1;
            end
            S_DONE: begin
                done = 1'b1;
                if (!start) state_d = S_IDLE;
            end
            S_FAULT: err = 1'b1;
            default: state_d = S_FAULT;
        endcase

        if (state_d != state_q) wait_d = '0;
        else if (waiting)       wait_d = wait_q + TO_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end
endmodule

// File: tb/tb_control_unit_hs.sv
// Bench for control_unit_hs: two instances (timeout off / ACK_TIMEOUT=4, wide IR)
// compared every cycle against a per-instruction timeline model.
module tb_control_unit_hs;
    typedef struct packed {
        logic       im_req;
        logic       dm_req;
        logic       dm_wr;
        logic [2:0] alu;
        logic [3:0] inc;
        logic [9:0] wr;
        logic [3:0] bus;
        logic       zw;
        logic       ready;
        logic       done;
        logic       err;
    } out_t;

    localparam logic [9:0] WR_AR = 10'b1000000000;
    localparam logic [9:0] WR_R  = 10'b0100000000;
    localparam logic [9:0] WR_PC = 10'b0010000000;
    localparam logic [9:0] WR_IR = 10'b0001000000;
    localparam logic [9:0] WR_RL = 10'b0000100000;
    localparam logic [9:0] WR_RC = 10'b0000010000;
    localparam logic [9:0] WR_RP = 10'b0000001000;
    localparam logic [9:0] WR_RQ = 10'b0000000100;
    localparam logic [9:0] WR_R1 = 10'b0000000010;
    localparam logic [9:0] WR_AC = 10'b0000000001;
    localparam logic [3:0] INC_PC = 4'b1000;

    logic       clk = 1'b0;
    logic       rst, start, Zout, imAck, dmAck;
    logic [7:0] ins_lo;
    logic [3:0] ins_hi;

    logic       im_req0, dm_req0, dm_wr0, zw0, ready0, done0, err0;
    logic [2:0] alu0;
    logic [3:0] inc0, bus0;
    logic [9:0] wr0;
    logic       im_req1, dm_req1, dm_wr1, zw1, ready1, done1, err1;
    logic [2:0] alu1;
    logic [3:0] inc1, bus1;
    logic [9:0] wr1;

    out_t  act0, act1, exp0, exp1;
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc_cnt = 0;
    int    ncyc;
    string tag_s = "";
    logic  chk_en = 1'b0;

    assign act0 = {im_req0, dm_req0, dm_wr0, alu0, inc0, wr0, bus0, zw0, ready0, done0, err0};
    assign act1 = {im_req1, dm_req1, dm_wr1, alu1, inc1, wr1, bus1, zw1, ready1, done1, err1};

    always #5 clk = ~clk;

    control_unit_hs u_dut0 (
        .clk(clk), .rst(rst), .start(start), .ins(ins_lo), .Zout(Zout),
        .imAck(imAck), .dmAck(dmAck), .imReq(im_req0), .dmReq(dm_req0),
        .DataMemWrEn(dm_wr0), .aluOp(alu0), .incReg(inc0), .wrEnReg(wr0),
        .busSel(bus0), .ZWrEn(zw0), .ready(ready0), .done(done0), .err(err0)
    );

    control_unit_hs #(.IR_WIDTH(12), .ACK_TIMEOUT(4), .TO_WIDTH(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .ins({ins_hi, ins_lo}), .Zout(Zout),
        .imAck(imAck), .dmAck(dmAck), .imReq(im_req1), .dmReq(dm_req1),
        .DataMemWrEn(dm_wr1), .aluOp(alu1), .incReg(inc1), .wrEnReg(wr1),
        .busSel(bus1), .ZWrEn(zw1), .ready(ready1), .done(done1), .err(err1)
    );

    function automatic out_t ev(input logic [9:0] wr, input logic [3:0] bus,
                                input logic [3:0] inc, input logic [2:0] alu, input logic zw);
        out_t e = '0;
        e.wr = wr; e.bus = bus; e.inc = inc; e.alu = alu; e.zw = zw;
        return e;
    endfunction

    function automatic out_t e_idle();  out_t e = '0; e.ready  = 1'b1; return e; endfunction
    function automatic out_t e_done();  out_t e = '0; e.done   = 1'b1; return e; endfunction
    function automatic out_t e_err();   out_t e = '0; e.err    = 1'b1; return e; endfunction
    function automatic out_t e_imreq(); out_t e = '0; e.im_req = 1'b1; return e; endfunction
    function automatic out_t e_dmreq(); out_t e = '0; e.dm_req = 1'b1; return e; endfunction

    function automatic logic [2:0] alu_code(input logic [7:0] op);
        case (op)
            8'd2:    return 3'd1;
            8'd10:   return 3'd4;
            8'd11:   return 3'd2;
            8'd12:   return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

    // MV n: 1..6 copy AC into a register, 7..9 copy RP/RQ/RL into AC.
    function automatic out_t e_mv(input logic [3:0] n);
        case (n)
            4'd1:    return ev(WR_RL, 4'd3, 4'd0, 3'd0, 1'b0);
            4'd2:    return ev(WR_RP, 4'd3, 4'd0, 3'd0, 1'b0);
            4'd3:    return ev(WR_RQ, 4'd3, 4'd0, 3'd0, 1'b0);
            4'd4:    return ev(WR_RC, 4'd3, 4'd0, 3'd0, 1'b0);
            4'd5:    return ev(WR_R,  4'd3, 4'd0, 3'd0, 1'b0);
            4'd6:    return ev(WR_R1, 4'd3, 4'd0, 3'd0, 1'b0);
            4'd7:    return ev(WR_AC, 4'd5, 4'd0, 3'd0, 1'b0);
            4'd8:    return ev(WR_AC, 4'd6, 4'd0, 3'd0, 1'b0);
            default: return ev(WR_AC, 4'd4, 4'd0, 3'd0, 1'b0);
        endcase
    endfunction

    task automatic step2(input string tag, input out_t e0, input out_t e1);
        tag_s  = tag;
        exp0   = e0;
        exp1   = e1;
        chk_en = 1'b1;
        cyc_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input out_t e);
        step2(tag, e, e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic kick();
        start = 1'b1;
        step("IDLE start", e_idle());
        start = 1'b0;
    endtask

    task automatic im_phase(input string tag, input int w, input out_t ack_e);
        for (int i = 0; i < w; i++) begin
            imAck = 1'b0;
            step({tag, " wait"}, e_imreq());
        end
        imAck = 1'b1;
        step({tag, " ack"}, ack_e);
        imAck = 1'b0;
    endtask

    task automatic ld_phase(input int w);
        out_t e;
        e = ev(WR_AC, 4'd0, 4'd0, 3'd0, 1'b1);
        e.dm_req = 1'b1;
        for (int i = 0; i < w; i++) begin
            dmAck = 1'b0;
            step("LD wait", e_dmreq());
        end
        dmAck = 1'b1;
        step("LD ack", e);
        dmAck = 1'b0;
    endtask

    task automatic st_phase(input int w);
        out_t e;
        e = ev(10'd0, 4'd3, 4'd0, 3'd0, 1'b0);
        e.dm_req = 1'b1;
        e.dm_wr  = 1'b1;
        for (int i = 0; i < w; i++) begin
            dmAck = 1'b0;
            step("ST wait", e);
        end
        dmAck = 1'b1;
        step("ST ack", e);
        dmAck = 1'b0;
    endtask

    // Fetch, decode, execute one legal instruction starting from FETCH1.
    task automatic run_instr(input logic [7:0] op, input logic z, input int imw,
                             input int opw, input int dmw, output int n);
        int   c0;
        out_t e;
        c0     = cyc_cnt;
        ins_lo = op;
        ins_hi = 4'($urandom);
        Zout   = z;
        imAck  = 1'b0;
        dmAck  = 1'b0;
        step($sformatf("op%02h FETCH1", op), ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
        e = ev(WR_IR, 4'd1, INC_PC, 3'd0, 1'b0);
        e.im_req = 1'b1;
        im_phase($sformatf("op%02h FETCH2", op), imw, e);
        step($sformatf("op%02h DECODE", op), '0);
        Zout = ~z;
        if (op == 8'd0) begin
        end else if (op inside {8'd2, 8'd10, 8'd11, 8'd12, 8'd13}) begin
            step($sformatf("op%02h ALU", op), ev(WR_AC, 4'd0, 4'd0, alu_code(op), 1'b1));
        end else if (op == 8'd4) begin
            ld_phase(dmw);
        end else if (op == 8'd5) begin
            st_phase(dmw);
        end else if (op inside {8'd3, 8'd6, 8'd7} || (op == 8'd9 && z) || (op == 8'd8 && !z)) begin
            step($sformatf("op%02h OPR1", op), ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
            if (op == 8'd3 || op == 8'd6) e = ev(WR_AR, 4'd1, INC_PC, 3'd0, 1'b0);
            else                          e = ev(WR_PC, 4'd1, 4'd0, 3'd0, 1'b0);
            e.im_req = 1'b1;
            im_phase($sformatf("op%02h OPR2", op), opw, e);
            if (op == 8'd3) ld_phase(dmw);
            if (op == 8'd6) st_phase(dmw);
        end else if (op == 8'd8 || op == 8'd9) begin
            step($sformatf("op%02h SKIP", op), ev(10'd0, 4'd0, INC_PC, 3'd0, 1'b0));
        end else begin
            step($sformatf("op%02h MV", op), e_mv(op[7:4]));
        end
        n = cyc_cnt - c0;
    endtask

    task automatic run_illegal(input logic [7:0] op);
        out_t e;
        ins_lo = op;
        ins_hi = 4'($urandom);
        step($sformatf("ill%02h FETCH1", op), ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
        e = ev(WR_IR, 4'd1, INC_PC, 3'd0, 1'b0);
        e.im_req = 1'b1;
        im_phase("ill FETCH2", 0, e);
        step("ill DECODE", '0);
        step("FAULT", e_err());
        start = 1'b1;
        step("FAULT start", e_err());
        start = 1'b0;
        imAck = 1'b1;
        step("FAULT ack", e_err());
        imAck = 1'b0;
        chk("fault err0 sticky", err0, 1);
        rst = 1'b1;
        step("FAULT rst", e_err());
        rst = 1'b0;
        step("IDLE after fault", e_idle());
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                n_chk++;
                if (act0 !== exp0) begin
                    n_fail++;
                    $display("FAIL %s [dut0] got %h required %h", tag_s, act0, exp0);
                end
                n_chk++;
                if (act1 !== exp1) begin
                    n_fail++;
                    $display("FAIL %s [dut1] got %h required %h", tag_s, act1, exp1);
                end
            end
        end
    end

    initial begin
        logic [7:0] alu_ops [4];
        alu_ops = '{8'd2, 8'd10, 8'd12, 8'd13};
        rst = 1'b1; start = 1'b0; Zout = 1'b0; imAck = 1'b0; dmAck = 1'b0;
        ins_lo = 8'd0; ins_hi = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset ready", ready0, 1);
        chk("reset wrEnReg", wr0, 0);
        chk("reset err", err1, 0);
        step("IDLE", e_idle());
        step("IDLE", e_idle());
        kick();

        run_instr(8'd11, 1'b0, 0, 0, 0, ncyc); chk("cycles ADD", ncyc, 4);
        run_instr(8'd0,  1'b0, 0, 0, 0, ncyc); chk("cycles NOP", ncyc, 3);
        foreach (alu_ops[i]) begin
            run_instr(alu_ops[i], 1'b1, 0, 0, 0, ncyc);
            chk($sformatf("cycles ALU %0d", alu_ops[i]), ncyc, 4);
        end
        run_instr(8'd5, 1'b0, 0, 0, 3, ncyc); chk("cycles STR dm+3", ncyc, 7);
        run_instr(8'd4, 1'b0, 0, 0, 0, ncyc); chk("cycles LDAC", ncyc, 4);
        run_instr(8'd4, 1'b1, 0, 0, 2, ncyc); chk("cycles LDAC dm+2", ncyc, 6);
        run_instr(8'd9, 1'b1, 0, 0, 0, ncyc); chk("cycles JMPZ taken", ncyc, 5);
        run_instr(8'd9, 1'b0, 0, 0, 0, ncyc); chk("cycles JMPZ skip", ncyc, 4);
        run_instr(8'd8, 1'b0, 0, 0, 0, ncyc); chk("cycles JMPNZ taken", ncyc, 5);
        run_instr(8'd8, 1'b1, 0, 0, 0, ncyc); chk("cycles JMPNZ skip", ncyc, 4);
        run_instr(8'd7, 1'b0, 0, 2, 0, ncyc); chk("cycles JUMP op+2", ncyc, 7);
        run_instr(8'd3, 1'b0, 0, 0, 0, ncyc); chk("cycles LDIAC", ncyc, 6);
        run_instr(8'd6, 1'b0, 0, 1, 1, ncyc); chk("cycles STIR op+1 dm+1", ncyc, 8);
        for (int n = 1; n <= 9; n++) begin
            run_instr({4'(n), 4'hF}, 1'b0, 0, 0, 0, ncyc);
            chk($sformatf("cycles MV %0d", n), ncyc, 4);
        end
        // Ack arriving exactly at the timeout limit must still be accepted.
        run_instr(8'd0, 1'b0, 4, 0, 0, ncyc); chk("cycles NOP im+4", ncyc, 7);
        run_instr(8'd5, 1'b0, 0, 0, 4, ncyc); chk("cycles STR dm+4", ncyc, 8);
        run_instr(8'd3, 1'b0, 1, 4, 4, ncyc); chk("cycles LDIAC waits", ncyc, 15);

        // ENDOP with start held: DONE persists until start drops.
        start = 1'b1;
        ins_lo = 8'd1;
        step("END FETCH1", ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
        begin
            out_t e;
            e = ev(WR_IR, 4'd1, INC_PC, 3'd0, 1'b0);
            e.im_req = 1'b1;
            im_phase("END FETCH2", 0, e);
        end
        step("END DECODE", '0);
        for (int i = 0; i < 3; i++) step("DONE start=1", e_done());
        chk("done held", done0, 1);
        start = 1'b0;
        step("DONE start=0", e_done());
        step("IDLE after done", e_idle());
        kick();

        run_illegal(8'hEE);
        kick();
        run_illegal(8'hAF);
        kick();
        run_illegal(8'h0F);

        // Instruction-fetch timeout: dut1 faults once 4 cycles passed without ack.
        kick();
        step("TO FETCH1", ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
        imAck = 1'b0;
        for (int k = 0; k < 8; k++)
            step2($sformatf("TO wait %0d", k), e_imreq(), (k <= 4) ? e_imreq() : e_err());
        chk("timeout err", err1, 1);
        start = 1'b1;
        step2("TO sticky", e_imreq(), e_err());
        start = 1'b0;
        rst = 1'b1;
        step2("TO rst", e_imreq(), e_err());
        rst = 1'b0;
        step("IDLE after timeout", e_idle());

        // Reset in the middle of a fetch wait.
        kick();
        step("MR FETCH1", ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
        step("MR wait", e_imreq());
        rst = 1'b1;
        step("MR rst", e_imreq());
        rst = 1'b0;
        step("IDLE after mid rst", e_idle());
        kick();
        run_instr(8'd11, 1'b0, 3, 0, 0, ncyc); chk("cycles ADD im+3", ncyc, 7);
        step("final FETCH1", ev(WR_AR, 4'd2, 4'd0, 3'd0, 1'b0));
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
